mesh_nic: RTL and testbench

Network interface controller between one processing element (PE) and its router's PE port in the 4x4 mesh.
- Injection side: accepts (destination, payload) requests from the PE, builds the 64-bit mesh packet header and queues the packet. It injects onto pesi/pedi under the router's peri credit and stamps the VC bit from polarity.
- Ejection side: buffers packets delivered on peso/pedo, drives pero backpressure, and presents source and payload to the PE with a valid/ready handshake.
- One instance per mesh node.

---
 rtl/mesh_pkg.sv | 30 +++
 rtl/nic_fifo.sv | 55 +++++
 rtl/mesh_nic.sv | 119 +++++++++++
 tb/tb_mesh_nic.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared packet layout and coordinate helpers for the mesh NIC.
package mesh_pkg;
    localparam int PKT_W   = 64;
    localparam int COORD_W = 2;

    localparam int VC_BIT   = 63;
    localparam int XDIR_BIT = 62;
    localparam int YDIR_BIT = 61;
    localparam int HOPX_MSB = 55;
    localparam int HOPX_LSB = 52;
    localparam int HOPY_MSB = 51;
    localparam int HOPY_LSB = 48;
    localparam int SRC_MSB  = 47;
    localparam int SRC_LSB  = 32;
    localparam int DATA_MSB = 31;
    localparam int DATA_LSB = 0;

    localparam int TXQ_W = PKT_W - 1;                 // everything but the VC bit
    localparam int RXQ_W = (SRC_MSB - DATA_LSB) + 1;  // source + payload

    // Unsigned hop distance, computed at 3 bits so the subtraction never wraps.
    function automatic logic [3:0] hop_mag(input logic [COORD_W-1:0] dst,
                                           input logic [COORD_W-1:0] here);
        logic [2:0] d;
        logic [2:0] h;
        d = {1'b0, dst};
        h = {1'b0, here};
        return (d >= h) ? {1'b0, d - h} : {1'b0, h - d};
    endfunction
endpackage

// File: rtl/nic_fifo.sv
// Synchronous FIFO with combinational head view; push is ignored when full, pop when empty.
module nic_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/mesh_nic.sv
// PE-side network interface: builds/injects mesh packets and buffers ejected ones for the PE.
module mesh_nic
    import mesh_pkg::*;
#(
    parameter int MY_X      = 0,
    parameter int MY_Y      = 0,
    parameter int TXQ_DEPTH = 4,
    parameter int RXQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               polarity,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [COORD_W-1:0] tx_dst_x,
    input  logic [COORD_W-1:0] tx_dst_y,
    input  logic [31:0]        tx_data,
    output logic               tx_err,
    output logic               pesi,
    output logic [PKT_W-1:0]   pedi,
    input  logic               peri,
    input  logic               peso,
    input  logic [PKT_W-1:0]   pedo,
    output logic               pero,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [15:0]        rx_src,
    output logic [31:0]        rx_data,
    output logic               rx_ovf
);
    localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

    logic             tx_self, tx_accept, tx_push;
    logic [TXQ_W-1:0] tx_entry, txq_head;
    logic             txq_full, txq_empty, txq_pop;
    logic             pesi_q, pesi_d;
    logic [PKT_W-1:0] pedi_q, pedi_d;
    logic             tx_err_q, tx_err_d;
    logic             rx_push, rx_pop, rxq_full, rxq_empty;
    logic [RXQ_W-1:0] rx_entry, rxq_head;
    logic             rx_ovf_q, rx_ovf_d;
    logic             pedo_unused;

    assign tx_self   = (tx_dst_x == MY_X_C) && (tx_dst_y == MY_Y_C);
    assign tx_ready  = ~txq_full;
    assign tx_accept = tx_valid & tx_ready;
    assign tx_push   = tx_accept & ~tx_self;
    assign txq_pop   = ~txq_empty & peri;

    always_comb begin
        tx_entry                     = '0;
        tx_entry[XDIR_BIT]           = (tx_dst_x < MY_X_C);
        tx_entry[YDIR_BIT]           = (tx_dst_y < MY_Y_C);
        tx_entry[HOPX_MSB:HOPX_LSB]  = hop_mag(tx_dst_x, MY_X_C);
        tx_entry[HOPY_MSB:HOPY_LSB]  = hop_mag(tx_dst_y, MY_Y_C);
        tx_entry[SRC_MSB:SRC_LSB]    = {8'(MY_X), 8'(MY_Y)};
        tx_entry[DATA_MSB:DATA_LSB]  = tx_data;
    end

    nic_fifo #(.W(TXQ_W), .DEPTH(TXQ_DEPTH)) u_txq (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (tx_entry),
        .pop       (txq_pop),
        .head      (txq_head),
        .full      (txq_full),
        .empty     (txq_empty)
    );

    // VC is stamped with the polarity seen at the pop edge, not at enqueue time.
    always_comb begin
        pesi_d   = txq_pop;
        pedi_d   = txq_pop ? {polarity, txq_head} : pedi_q;
        tx_err_d = tx_accept & tx_self;
        rx_ovf_d = rx_ovf_q | (peso & ~pero);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pesi_q   <= 1'b0;
            pedi_q   <= '0;
            tx_err_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            pesi_q   <= pesi_d;
            pedi_q   <= pedi_d;
            tx_err_q <= tx_err_d;
            rx_ovf_q <= rx_ovf_d;
        end
    end

    assign pesi   = pesi_q;
    assign pedi   = pedi_q;
    assign tx_err = tx_err_q;
    assign rx_ovf = rx_ovf_q;

    assign pero        = ~rxq_full;
    assign rx_push     = peso & pero;
    assign rx_valid    = ~rxq_empty;
    assign rx_pop      = rx_valid & rx_ready;
    assign rx_entry    = {pedo[SRC_MSB:SRC_LSB], pedo[DATA_MSB:DATA_LSB]};
    assign pedo_unused = ^pedo[PKT_W-1:HOPY_LSB];

    nic_fifo #(.W(RXQ_W), .DEPTH(RXQ_DEPTH)) u_rxq (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_entry),
        .pop       (rx_pop),
        .head      (rxq_head),
        .full      (rxq_full),
        .empty     (rxq_empty)
    );

    assign rx_src  = rxq_head[RXQ_W-1:32];
    assign rx_data = rxq_head[31:0];
endmodule

// File: tb/tb_mesh_nic.sv
// Self-checking bench for mesh_nic at node (1,1): directed scenarios plus a randomized run against a queue model.
module tb_mesh_nic;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        polarity = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [1:0]  tx_dst_x = 2'd0;
    logic [1:0]  tx_dst_y = 2'd0;
    logic [31:0] tx_data = 32'd0;
    logic        tx_err;
    logic        pesi;
    logic [63:0] pedi;
    logic        peri = 1'b0;
    logic        peso = 1'b0;
    logic [63:0] pedo = 64'd0;
    logic        pero;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [15:0] rx_src;
    logic [31:0] rx_data;
    logic        rx_ovf;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mesh_nic #(.MY_X(1), .MY_Y(1), .TXQ_DEPTH(4), .RXQ_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y),
        .tx_data(tx_data), .tx_err(tx_err),
        .pesi(pesi), .pedi(pedi), .peri(peri),
        .peso(peso), .pedo(pedo), .pero(pero),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src(rx_src), .rx_data(rx_data), .rx_ovf(rx_ovf)
    );

    // Expected packet (without VC) for node (1,1), straight from the field definitions.
    function automatic logic [62:0] model_pkt(input int dx, input int dy, input logic [31:0] d);
        int hx, hy;
        hx = (dx > 1) ? dx - 1 : 1 - dx;
        hy = (dy > 1) ? dy - 1 : 1 - dy;
        return {(dx < 1), (dy < 1), 5'b0, 4'(hx), 4'(hy), 8'd1, 8'd1, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; tx_valid = 1'b0; peri = 1'b0; peso = 1'b0; rx_ready = 1'b0; polarity = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        total++; if (pesi !== 1'b0)      $display("FAIL rst_pesi: got %b want 0", pesi); else passed++;
        total++; if (pedi !== 64'd0)     $display("FAIL rst_pedi: got %h want 0", pedi); else passed++;
        total++; if (tx_err !== 1'b0)    $display("FAIL rst_tx_err: got %b want 0", tx_err); else passed++;
        total++; if (rx_ovf !== 1'b0)    $display("FAIL rst_rx_ovf: got %b want 0", rx_ovf); else passed++;
        total++; if (tx_ready !== 1'b1)  $display("FAIL rst_tx_ready: got %b want 1", tx_ready); else passed++;
        total++; if (pero !== 1'b1)      $display("FAIL rst_pero: got %b want 1", pero); else passed++;
        total++; if (rx_valid !== 1'b0)  $display("FAIL rst_rx_valid: got %b want 0", rx_valid); else passed++;
        reset = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic inject_one(input logic [1:0] dx, input logic [1:0] dy, input logic [31:0] d,
                              input logic pol, input logic [63:0] exp_pkt, input string nm);
        apply_reset();
        peri = 1'b1; tx_dst_x = dx; tx_dst_y = dy; tx_data = d; tx_valid = 1'b1; polarity = ~pol;
        tick();
        tx_valid = 1'b0; polarity = pol;
        total++; if (pesi !== 1'b0) $display("FAIL %s_lat1: pesi got %b want 0", nm, pesi); else passed++;
        tick();
        polarity = ~pol;
        total++; if (pesi !== 1'b1) $display("FAIL %s_lat2: pesi got %b want 1", nm, pesi); else passed++;
        total++; if (pedi !== exp_pkt) $display("FAIL %s_pkt: pedi got %h want %h", nm, pedi, exp_pkt); else passed++;
        $display("%s: injected pedi=%h", nm, pedi);
        tick();
        total++; if (pesi !== 1'b0) $display("FAIL %s_once: pesi got %b want 0", nm, pesi); else passed++;
    endtask

    task automatic test_inject();
        inject_one(2'd0, 2'd0, 32'h4444_4444, 1'b0,
                   {1'b0, 2'b11, 5'b0, 8'h11, 16'h0101, 32'h4444_4444}, "inj_sw");
        inject_one(2'd3, 2'd2, 32'hEEEE_EEEE, 1'b1,
                   {1'b1, 2'b00, 5'b0, 8'h21, 16'h0101, 32'hEEEE_EEEE}, "inj_ne");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        peri = 1'b0; tx_dst_x = 2'd2; tx_dst_y = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tx_data = 32'hA000_0000 + 32'(i); tx_valid = 1'b1;
            total++; if (tx_ready !== (i < 4)) $display("FAIL b2b_ready%0d: got %b want %b", i, tx_ready, (i < 4)); else passed++;
            tick();
            total++; if (pesi !== 1'b0) $display("FAIL b2b_hold%0d: pesi got %b want 0", i, pesi); else passed++;
        end
        tx_valid = 1'b0; peri = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++; if (pesi !== 1'b1) $display("FAIL b2b_pesi%0d: got %b want 1", i, pesi); else passed++;
            total++; if (pedi[31:0] !== 32'hA000_0000 + 32'(i))
                $display("FAIL b2b_data%0d: got %h want %h", i, pedi[31:0], 32'hA000_0000 + 32'(i)); else passed++;
            $display("b2b: injection %0d data=%h", i, pedi[31:0]);
            tick();
        end
        total++; if (pesi !== 1'b0) $display("FAIL b2b_drain: pesi got %b want 0", pesi); else passed++;
        total++; if (tx_ready !== 1'b1) $display("FAIL b2b_ready_end: got %b want 1", tx_ready); else passed++;
    endtask

    task automatic test_self_err();
        int seen;
        apply_reset();
        peri = 1'b0; tx_dst_x = 2'd0; tx_dst_y = 2'd2; tx_valid = 1'b1;
        tick(); tick();
        tx_dst_x = 2'd1; tx_dst_y = 2'd1; tx_data = 32'h5E1F_5E1F;
        tick();
        tx_valid = 1'b0;
        total++; if (tx_err !== 1'b1) $display("FAIL self_err_pulse: got %b want 1", tx_err); else passed++;
        tick();
        total++; if (tx_err !== 1'b0) $display("FAIL self_err_clear: got %b want 0", tx_err); else passed++;
        peri = 1'b1; seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pesi === 1'b1) seen++;
        end
        total++; if (seen !== 2) $display("FAIL self_err_count: injections got %0d want 2", seen); else passed++;
        $display("self_err: %0d packets injected after self-addressed drop", seen);
    endtask

    task automatic test_eject();
        apply_reset();
        rx_ready = 1'b0; peso = 1'b1;
        pedo = {16'h1234, 16'h0203, 32'hBBBB_BBBB};
        total++; if (pero !== 1'b1) $display("FAIL ej_pero0: got %b want 1", pero); else passed++;
        tick();
        pedo = {16'hFFFF, 16'h0102, 32'hCCCC_CCCC};
        total++; if (pero !== 1'b1) $display("FAIL ej_pero1: got %b want 1", pero); else passed++;
        tick();
        total++; if (pero !== 1'b0) $display("FAIL ej_pero2: got %b want 0", pero); else passed++;
        total++; if (rx_ovf !== 1'b0) $display("FAIL ej_ovf_early: got %b want 0", rx_ovf); else passed++;
        pedo = {16'h0000, 16'h0303, 32'hDDDD_DDDD};
        tick();
        peso = 1'b0;
        total++; if (rx_ovf !== 1'b1) $display("FAIL ej_ovf: got %b want 1", rx_ovf); else passed++;
        total++; if (rx_valid !== 1'b1) $display("FAIL ej_valid0: got %b want 1", rx_valid); else passed++;
        total++; if (rx_src !== 16'h0203) $display("FAIL ej_src0: got %h want 0203", rx_src); else passed++;
        total++; if (rx_data !== 32'hBBBB_BBBB) $display("FAIL ej_data0: got %h want bbbbbbbb", rx_data); else passed++;
        $display("eject: head src=%h data=%h", rx_src, rx_data);
        rx_ready = 1'b1;
        tick();
        total++; if (rx_src !== 16'h0102) $display("FAIL ej_src1: got %h want 0102", rx_src); else passed++;
        total++; if (rx_data !== 32'hCCCC_CCCC) $display("FAIL ej_data1: got %h want cccccccc", rx_data); else passed++;
        $display("eject: head src=%h data=%h", rx_src, rx_data);
        tick();
        total++; if (rx_valid !== 1'b0) $display("FAIL ej_empty: got %b want 0", rx_valid); else passed++;
        rx_ready = 1'b0;
    endtask

    // Runs directly after test_eject so rx_ovf is still set going in.
    task automatic test_reset_mid();
        peri = 1'b0; tx_dst_x = 2'd3; tx_dst_y = 2'd3; tx_valid = 1'b1;
        peso = 1'b1; pedo = {16'h0, 16'h0001, 32'h1111_1111};
        tick();
        peso = 1'b0;
        tick(); tick(); tick();
        tx_valid = 1'b0; peri = 1'b1;
        tick();
        total++; if (pesi !== 1'b1) $display("FAIL rmid_pre_pesi: got %b want 1", pesi); else passed++;
        total++; if (rx_valid !== 1'b1) $display("FAIL rmid_pre_rxv: got %b want 1", rx_valid); else passed++;
        reset = 1'b1;
        tick();
        total++; if (pesi !== 1'b0) $display("FAIL rmid_pesi: got %b want 0", pesi); else passed++;
        total++; if (tx_ready !== 1'b1) $display("FAIL rmid_tx_ready: got %b want 1", tx_ready); else passed++;
        total++; if (rx_valid !== 1'b0) $display("FAIL rmid_rx_valid: got %b want 0", rx_valid); else passed++;
        total++; if (rx_ovf !== 1'b0) $display("FAIL rmid_rx_ovf: got %b want 0", rx_ovf); else passed++;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (pesi !== 1'b0) $display("FAIL rmid_no_inj%0d: pesi got %b want 0", i, pesi); else passed++;
        end
        $display("reset_mid: queues flushed");
    endtask

    task automatic test_random();
        logic [62:0] txm[$];
        logic [47:0] rxm[$];
        logic        ovf_m, exp_pesi, exp_err, tx_pop, tx_acc, rx_pop_m, rx_full_m;
        logic [63:0] exp_pedi;
        int          n_inj;
        apply_reset();
        ovf_m = 1'b0; exp_pesi = 1'b0; exp_err = 1'b0; exp_pedi = 64'd0; n_inj = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            total++; if (tx_ready !== (txm.size() < 4)) $display("FAIL rnd_tx_ready c%0d: got %b want %b", cyc, tx_ready, (txm.size() < 4)); else passed++;
            total++; if (pero !== (rxm.size() < 2)) $display("FAIL rnd_pero c%0d: got %b want %b", cyc, pero, (rxm.size() < 2)); else passed++;
            total++; if (rx_valid !== (rxm.size() > 0)) $display("FAIL rnd_rx_valid c%0d: got %b want %b", cyc, rx_valid, (rxm.size() > 0)); else passed++;
            if (rxm.size() > 0) begin
                total++; if ({rx_src, rx_data} !== rxm[0]) $display("FAIL rnd_rx_head c%0d: got %h want %h", cyc, {rx_src, rx_data}, rxm[0]); else passed++;
            end
            total++; if (rx_ovf !== ovf_m) $display("FAIL rnd_ovf c%0d: got %b want %b", cyc, rx_ovf, ovf_m); else passed++;
            total++; if (pesi !== exp_pesi) $display("FAIL rnd_pesi c%0d: got %b want %b", cyc, pesi, exp_pesi); else passed++;
            total++; if (pedi !== exp_pedi) $display("FAIL rnd_pedi c%0d: got %h want %h", cyc, pedi, exp_pedi); else passed++;
            total++; if (tx_err !== exp_err) $display("FAIL rnd_tx_err c%0d: got %b want %b", cyc, tx_err, exp_err); else passed++;

            tx_valid = 1'($urandom_range(0, 1));
            tx_dst_x = 2'($urandom_range(0, 3));
            tx_dst_y = 2'($urandom_range(0, 3));
            tx_data  = $urandom;
            peri     = ($urandom_range(0, 2) == 0);
            polarity = 1'($urandom_range(0, 1));
            peso     = 1'($urandom_range(0, 1));
            pedo     = {$urandom, $urandom};
            rx_ready = ($urandom_range(0, 2) == 0);

            tx_pop = (txm.size() > 0) && peri;
            tx_acc = tx_valid && (txm.size() < 4);
            exp_pesi = tx_pop;
            exp_err  = tx_acc && (tx_dst_x == 2'd1) && (tx_dst_y == 2'd1);
            if (tx_pop) begin
                exp_pedi = {polarity, txm.pop_front()};
                n_inj++;
            end
            if (tx_acc && !exp_err) txm.push_back(model_pkt(int'(tx_dst_x), int'(tx_dst_y), tx_data));
            rx_full_m = (rxm.size() >= 2);
            rx_pop_m  = rx_ready && (rxm.size() > 0);
            if (peso && rx_full_m) ovf_m = 1'b1;
            if (rx_pop_m) void'(rxm.pop_front());
            if (peso && !rx_full_m) rxm.push_back({pedo[47:32], pedo[31:0]});
            tick();
        end
        tx_valid = 1'b0; peso = 1'b0; peri = 1'b0; rx_ready = 1'b0;
        $display("random: 600 cycles, %0d injections modelled", n_inj);
    endtask

    initial begin
        test_reset();
        test_inject();
        test_back_to_back();
        test_self_err();
        test_eject();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
